// File: rtl/lvds_sched_pkg.sv
// Shared types and constants for the LVDS transmit scheduler.
// Lane indices, bus widths, FSM state encoding and a lane-mask helper.
package lvds_sched_pkg;

   localparam int CMD_W     = 5;
   localparam int DATA_W    = 32;
   localparam int LANE_CMD  = 0;
   localparam int LANE_DATA = 1;

   typedef enum logic [1:0] {
      IDLE,
      LAUNCH,
      WAIT_ACK,
      WAIT_DONE
   } state_t;

   // Lanes a transaction occupies: command always, data only when present.
   function automatic logic [1:0] lanes_used(input logic has_data);
      logic [1:0] l;
      l            = '0;
      l[LANE_CMD]  = 1'b1;
      l[LANE_DATA] = has_data;
      return l;
   endfunction

endpackage

// File: rtl/lvds_tx_scheduler_if.sv
// Requester and serializer signal bundle for lvds_tx_scheduler.
// slave = scheduler side, master = requesters plus serializer side.
interface lvds_tx_scheduler_if #(
   parameter int N_REQ = 4
);
   import lvds_sched_pkg::*;

   logic [N_REQ-1:0]        req_i;
   logic [CMD_W*N_REQ-1:0]  req_cmd_i;
   logic [DATA_W*N_REQ-1:0] req_data_i;
   logic [N_REQ-1:0]        req_has_data_i;
   logic [N_REQ-1:0]        gnt_o;
   logic [N_REQ-1:0]        done_o;
   logic [CMD_W-1:0]        command_o;
   logic [DATA_W-1:0]       data_o;
   logic [1:0]              start_o;
   logic [1:0]              lvds_busy_i;
   logic                    sched_busy_o;
   logic                    timeout_o;

   modport slave (
      input  req_i,
      input  req_cmd_i,
      input  req_data_i,
      input  req_has_data_i,
      input  lvds_busy_i,
      output gnt_o,
      output done_o,
      output command_o,
      output data_o,
      output start_o,
      output sched_busy_o,
      output timeout_o
   );

   modport master (
      output req_i,
      output req_cmd_i,
      output req_data_i,
      output req_has_data_i,
      output lvds_busy_i,
      input  gnt_o,
      input  done_o,
      input  command_o,
      input  data_o,
      input  start_o,
      input  sched_busy_o,
      input  timeout_o
   );

endinterface

// File: rtl/lvds_rr_arbiter.sv
// Round-robin arbiter: one-hot grant from the request vector.
// Search starts one past the last winner; advance commits the winner.
module lvds_rr_arbiter #(
   parameter int N_REQ = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_REQ-1:0] req,
   input  logic             advance,
   output logic [N_REQ-1:0] grant
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [IDX_W-1:0] last;
   logic [IDX_W-1:0] pick;
   logic             found;

   // Scan requesters in rotated order and take the first one asserted.
   always_comb begin
      grant = '0;
      pick  = last;
      found = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         int idx;
         idx = (int'(last) + 1 + k) % N_REQ;
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            pick       = IDX_W'(idx);
         end
      end
   end

   // Remember the committed winner; reset makes requester 0 first in line.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last <= IDX_W'(N_REQ - 1);
      end else if (advance && found) begin
         last <= pick;
      end
   end

endmodule

// File: rtl/lvds_tx_scheduler.sv
// Shares the two-lane LVDS serializer between N_REQ requesters.
// Optional abort-on-stall watchdog: define LVDS_TIMEOUT_EN.
module lvds_tx_scheduler
   import lvds_sched_pkg::*;
#(
   parameter int N_REQ       = 4,
   parameter int TIMEOUT_CYC = 1024
) (
   input logic           clk,
   input logic           reset,
   lvds_tx_scheduler_if.slave bus
);

   if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
      $error("N_REQ must be within 2..8");
   end
   if (TIMEOUT_CYC < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYC must be at least 1");
   end

   state_t            state;
   logic [N_REQ-1:0]  grant;
   logic [N_REQ-1:0]  owner;
   logic [1:0]        lanes;
   logic              fire;
   logic              expired;
   logic [CMD_W-1:0]  sel_cmd;
   logic [DATA_W-1:0] sel_data;
   logic              sel_has;

   assign fire = (state == IDLE) && (|bus.req_i) &&
                 (bus.lvds_busy_i == 2'b00);

   lvds_rr_arbiter #(
      .N_REQ (N_REQ)
   ) u_arb (
      .clk     (clk),
      .reset   (reset),
      .req     (bus.req_i),
      .advance (fire),
      .grant   (grant)
   );

   // One-hot mux of the winning requester's transaction fields.
   always_comb begin
      sel_cmd  = '0;
      sel_data = '0;
      sel_has  = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant[i]) begin
            sel_cmd  = sel_cmd  | bus.req_cmd_i[i*CMD_W +: CMD_W];
            sel_data = sel_data | bus.req_data_i[i*DATA_W +: DATA_W];
            sel_has  = sel_has  | bus.req_has_data_i[i];
         end
      end
   end

`ifdef LVDS_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

   logic [CNT_W-1:0] cnt;

   // Cycles spent waiting on the serializer since the launch.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (state == LAUNCH) begin
         cnt <= '0;
      end else if (state == WAIT_ACK || state == WAIT_DONE) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign expired = (state == WAIT_ACK || state == WAIT_DONE) &&
                    (cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
   assign expired = 1'b0;
`endif

   // Transfer sequencer; every output is registered here.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state            <= IDLE;
         owner            <= '0;
         lanes            <= '0;
         bus.gnt_o        <= '0;
         bus.done_o       <= '0;
         bus.start_o      <= '0;
         bus.command_o    <= '0;
         bus.data_o       <= '0;
         bus.sched_busy_o <= 1'b0;
         bus.timeout_o    <= 1'b0;
      end else begin
         bus.gnt_o     <= '0;
         bus.done_o    <= '0;
         bus.start_o   <= '0;
         bus.timeout_o <= 1'b0;
         unique case (state)
            IDLE: begin
               if (fire) begin
                  bus.gnt_o        <= grant;
                  owner            <= grant;
                  lanes            <= lanes_used(sel_has);
                  bus.command_o    <= sel_cmd;
                  bus.data_o       <= sel_has ? sel_data : '0;
                  bus.sched_busy_o <= 1'b1;
                  state            <= LAUNCH;
               end
            end
            LAUNCH: begin
               bus.start_o <= lanes;
               state       <= WAIT_ACK;
            end
            WAIT_ACK: begin
               if (expired) begin
                  bus.timeout_o    <= 1'b1;
                  bus.sched_busy_o <= 1'b0;
                  bus.command_o    <= '0;
                  bus.data_o       <= '0;
                  state            <= IDLE;
               end else if ((bus.lvds_busy_i & lanes) == lanes) begin
                  state <= WAIT_DONE;
               end
            end
            WAIT_DONE: begin
               if (bus.lvds_busy_i == 2'b00) begin
                  bus.done_o       <= owner;
                  bus.sched_busy_o <= 1'b0;
                  bus.command_o    <= '0;
                  bus.data_o       <= '0;
                  state            <= IDLE;
               end else if (expired) begin
                  bus.timeout_o    <= 1'b1;
                  bus.sched_busy_o <= 1'b0;
                  bus.command_o    <= '0;
                  bus.data_o       <= '0;
                  state            <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lvds_tx_scheduler.sv
// Directed bench for lvds_tx_scheduler with hand-derived expectations.
// The timeout scenario is included when LVDS_TIMEOUT_EN is defined.
module tb_lvds_tx_scheduler;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   lvds_tx_scheduler_if #(.N_REQ(4)) bus ();

   lvds_tx_scheduler #(
      .N_REQ       (4),
      .TIMEOUT_CYC (16)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expects a grant on the next edge (bounded), then a command-only transfer.
   task automatic xfer(input string tag, input logic [3:0] exp);
      int n;
      n = 0;
      tick();
      while (bus.gnt_o == 4'b0 && n < 20) begin
         tick();
         n++;
      end
      chk({tag, "_gnt"}, bus.gnt_o, exp);
      chk({tag, "_done_at_gnt"}, bus.done_o, 4'b0);
      tick();
      chk({tag, "_start"}, bus.start_o, 2'b01);
      bus.lvds_busy_i = 2'b01;
      tick();
      tick();
      bus.lvds_busy_i = 2'b00;
      tick();
      chk({tag, "_done"}, bus.done_o, exp);
      chk({tag, "_gnt_at_done"}, bus.gnt_o, 4'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   initial begin
      checks             = 0;
      errors             = 0;
      reset              = 1'b1;
      bus.req_i          = '0;
      bus.req_cmd_i      = '0;
      bus.req_data_i     = '0;
      bus.req_has_data_i = '0;
      bus.lvds_busy_i    = 2'b00;
      tick();
      tick();
      chk("rst_gnt", bus.gnt_o, 4'b0);
      chk("rst_start", bus.start_o, 2'b0);
      chk("rst_sbusy", bus.sched_busy_o, 1'b0);
      chk("rst_cmd", bus.command_o, 5'h0);
      reset = 1'b0;
      tick();

      // 1: command-only transfer from requester 0
      bus.req_cmd_i[4:0] = 5'h13;
      bus.req_i          = 4'b0001;
      tick();
      chk("t1_gnt", bus.gnt_o, 4'b0001);
      chk("t1_sbusy", bus.sched_busy_o, 1'b1);
      chk("t1_start_early", bus.start_o, 2'b00);
      bus.req_i = 4'b0000;
      tick();
      chk("t1_start", bus.start_o, 2'b01);
      chk("t1_cmd", bus.command_o, 5'h13);
      chk("t1_gnt_off", bus.gnt_o, 4'b0);
      tick();
      chk("t1_start_off", bus.start_o, 2'b00);
      bus.lvds_busy_i = 2'b01;
      tick();
      tick();
      chk("t1_done_early", bus.done_o, 4'b0);
      chk("t1_cmd_hold", bus.command_o, 5'h13);
      bus.lvds_busy_i = 2'b00;
      tick();
      chk("t1_done", bus.done_o, 4'b0001);
      chk("t1_sbusy_off", bus.sched_busy_o, 1'b0);
      tick();
      chk("t1_done_off", bus.done_o, 4'b0);

      // 2: command plus data from requester 1
      bus.req_cmd_i[9:5]         = 5'h05;
      bus.req_data_i[63:32]      = 32'hDEADBEEF;
      bus.req_has_data_i         = 4'b0010;
      bus.req_i                  = 4'b0010;
      tick();
      chk("t2_gnt", bus.gnt_o, 4'b0010);
      bus.req_i = 4'b0000;
      tick();
      chk("t2_start", bus.start_o, 2'b11);
      chk("t2_data", bus.data_o, 32'hDEADBEEF);
      chk("t2_cmd", bus.command_o, 5'h05);
      tick();
      bus.lvds_busy_i = 2'b11;
      tick();
      bus.lvds_busy_i = 2'b10;
      tick();
      chk("t2_done_lane1", bus.done_o, 4'b0);
      tick();
      chk("t2_done_lane1b", bus.done_o, 4'b0);
      chk("t2_data_hold", bus.data_o, 32'hDEADBEEF);
      chk("t2_tmo", bus.timeout_o, 1'b0);
      bus.lvds_busy_i = 2'b00;
      tick();
      chk("t2_done", bus.done_o, 4'b0010);
      bus.req_has_data_i = 4'b0000;
      tick();

      // 4: serializer busy in IDLE blocks the grant
      bus.lvds_busy_i = 2'b01;
      bus.req_i       = 4'b0100;
      tick();
      chk("t4_blk0", bus.gnt_o, 4'b0);
      tick();
      tick();
      chk("t4_blk2", bus.gnt_o, 4'b0);
      chk("t4_sbusy", bus.sched_busy_o, 1'b0);
      bus.lvds_busy_i = 2'b00;
      xfer("t4", 4'b0100);
      bus.req_i = 4'b0000;
      tick();

      // 5: reset while waiting for completion
      bus.req_i = 4'b0100;
      tick();
      chk("t5_gnt", bus.gnt_o, 4'b0100);
      bus.req_i = 4'b0000;
      tick();
      bus.lvds_busy_i = 2'b01;
      tick();
      tick();
      chk("t5_sbusy", bus.sched_busy_o, 1'b1);
      reset = 1'b1;
      #1;
      chk("t5_rst_sbusy", bus.sched_busy_o, 1'b0);
      chk("t5_rst_cmd", bus.command_o, 5'h0);
      chk("t5_rst_start", bus.start_o, 2'b0);
      bus.lvds_busy_i = 2'b00;
      tick();
      chk("t5_rst_done", bus.done_o, 4'b0);
      reset = 1'b0;
      tick();
      chk("t5_no_done", bus.done_o, 4'b0);

      // 3: all requesters held, rotation starts at 0 after reset
      bus.req_i = 4'b1111;
      xfer("t3a", 4'b0001);
      xfer("t3b", 4'b0010);
      xfer("t3c", 4'b0100);
      xfer("t3d", 4'b1000);
      xfer("t3e", 4'b0001);
      bus.req_i = 4'b0000;
      tick();
      tick();
      chk("t3_idle", bus.sched_busy_o, 1'b0);

`ifdef LVDS_TIMEOUT_EN
      // 6: serializer never acknowledges
      begin
         int n;
         bus.req_i = 4'b1000;
         tick();
         chk("t6_gnt", bus.gnt_o, 4'b1000);
         bus.req_i = 4'b0000;
         tick();
         n = 0;
         do begin
            tick();
            n++;
         end while (!bus.timeout_o && n < 40);
         chk("t6_cycles", 64'(n), 64'd16);
         chk("t6_done", bus.done_o, 4'b0);
         chk("t6_sbusy", bus.sched_busy_o, 1'b0);
         tick();
         chk("t6_tmo_off", bus.timeout_o, 1'b0);
      end
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
